sim_run_ctrl: RTL and testbench

- Run controller clocked by the free-running testbench clock generator; sits directly downstream of it.
- Counts cycles of a test run and decides pass, fail or timeout. Lets a fixed drain window elapse, then emits a single-cycle finish request to the bench's $finish logic.
- Replaces ad-hoc "if (cyc == N) $finish" blocks with one checked, synthesizable sequencer.

---
 rtl/sim_run_ctrl.sv | 139 +++++++++++++
 tb/tb_sim_run_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: cycle-counting run sequencer for a test bench.
// A run starts on `start`, ends on error, completion or timeout, waits a
// fixed drain window, then pulses finish_o once and holds the verdict.
//
// Handshake: there is no valid/ready pair here. start, done_i and err_i are
// plain levels sampled at posedge clk in the states listed on each port, and
// finish_o is a single-cycle strobe with no back-pressure.
module sim_run_ctrl #(
  parameter int CYC_W     = 32,
  parameter int MAX_CYC   = 10,
  parameter int DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             done_i,
  input  logic             err_i,
  output logic [CYC_W-1:0] cyc_o,
  output logic             busy_o,
  output logic             finish_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Drain counter only needs to reach DRAIN_CYC-1; keep at least one bit.
  localparam int DW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0]    DRAIN_LAST = (DRAIN_CYC == 0) ? '0 : DW'(DRAIN_CYC - 1);
  localparam logic [CYC_W-1:0] MAX_CNT    = CYC_W'(MAX_CYC);
  localparam logic [CYC_W-1:0] CYC_ONES   = '1;

  // state_q is left as a named enum so checkers can bind to it directly.
  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic             finish_q, finish_d;
  logic             run_exit;

  // State register and datapath flops; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      drain_q   <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      drain_q   <= drain_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      finish_q  <= finish_d;
    end
  end

  // Next-state, cycle count, drain count and verdict flag logic.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    drain_d   = drain_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    finish_d  = 1'b0;
    run_exit  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          cyc_d     = '0;
          drain_d   = '0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_RUN: begin
        cyc_d = (cyc_q == CYC_ONES) ? cyc_q : cyc_q + CYC_W'(1);
        // Error outranks completion, completion outranks timeout.
        if (err_i) begin
          run_exit = 1'b1;
          fail_d   = 1'b1;
        end else if (done_i) begin
          run_exit = 1'b1;
          pass_d   = 1'b1;
        end else if (cyc_q == MAX_CNT) begin
          run_exit  = 1'b1;
          fail_d    = 1'b1;
          timeout_d = 1'b1;
        end
        if (run_exit) begin
          drain_d = '0;
          if (DRAIN_CYC == 0) begin
            state_d  = S_DONE;
            finish_d = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        cyc_d   = (cyc_q == CYC_ONES) ? cyc_q : cyc_q + CYC_W'(1);
        drain_d = drain_q + DW'(1);
        // A late error demotes a pass; a timeout already carries fail.
        if (err_i) begin
          pass_d = 1'b0;
          fail_d = 1'b1;
        end
        if (drain_q == DRAIN_LAST) begin
          state_d  = S_DONE;
          finish_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cyc_o     = cyc_q;
  assign busy_o    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign finish_o  = finish_q;
  assign pass_o    = (state_q == S_DONE) && pass_q;
  assign fail_o    = (state_q == S_DONE) && fail_q;
  assign timeout_o = (state_q == S_DONE) && timeout_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: instance a uses the default drain window
// of 2 cycles, instance b uses a zero-length drain window.
module tb_sim_run_ctrl;

  logic        clk;
  logic        rst;
  logic        start_a, done_a, err_a;
  logic [31:0] cyc_a;
  logic        busy_a, finish_a, pass_a, fail_a, timeout_a;
  logic        start_b, done_b, err_b;
  logic [31:0] cyc_b;
  logic        busy_b, finish_b, pass_b, fail_b, timeout_b;

  int vec_cnt;
  int miss_cnt;

  // Clock and reset generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sim_run_ctrl #(.CYC_W(32), .MAX_CYC(10), .DRAIN_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .done_i(done_a), .err_i(err_a),
    .cyc_o(cyc_a), .busy_o(busy_a), .finish_o(finish_a),
    .pass_o(pass_a), .fail_o(fail_a), .timeout_o(timeout_a)
  );

  sim_run_ctrl #(.CYC_W(32), .MAX_CYC(10), .DRAIN_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .done_i(done_b), .err_i(err_b),
    .cyc_o(cyc_b), .busy_o(busy_b), .finish_o(finish_b),
    .pass_o(pass_b), .fail_o(fail_b), .timeout_o(timeout_b)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start on instance a for exactly one edge (that edge is E0).
  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    if (cyc_a !== 32'd0) begin miss_cnt++; $display("FAIL reset_cyc_a got %0d exp 0", cyc_a); end
    vec_cnt++;
    if ({busy_a, finish_a, pass_a, fail_a, timeout_a} !== 5'b0) begin
      miss_cnt++; $display("FAIL reset_flags_a got %b exp 00000", {busy_a, finish_a, pass_a, fail_a, timeout_a});
    end
    vec_cnt++;
    if (cyc_b !== 32'd0) begin miss_cnt++; $display("FAIL reset_cyc_b got %0d exp 0", cyc_b); end
    vec_cnt++;
    if ({busy_b, finish_b, pass_b, fail_b, timeout_b} !== 5'b0) begin
      miss_cnt++; $display("FAIL reset_flags_b got %b exp 00000", {busy_b, finish_b, pass_b, fail_b, timeout_b});
    end
    vec_cnt++;
  endtask

  // Run on instance a with no done/err; expect DONE at E13 with timeout.
  task automatic test_timeout();
    pulse_start_a();
    if (cyc_a !== 32'd0 || busy_a !== 1'b1) begin
      miss_cnt++; $display("FAIL timeout_e0 got cyc=%0d busy=%b exp cyc=0 busy=1", cyc_a, busy_a);
    end
    vec_cnt++;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (cyc_a !== 32'(k)) begin miss_cnt++; $display("FAIL timeout_cyc E%0d got %0d exp %0d", k, cyc_a, k); end
      vec_cnt++;
      if (busy_a !== (k < 13)) begin miss_cnt++; $display("FAIL timeout_busy E%0d got %b exp %b", k, busy_a, k < 13); end
      vec_cnt++;
      if (finish_a !== (k == 13)) begin miss_cnt++; $display("FAIL timeout_finish E%0d got %b exp %b", k, finish_a, k == 13); end
      vec_cnt++;
    end
    if ({pass_a, fail_a, timeout_a} !== 3'b011) begin
      miss_cnt++; $display("FAIL timeout_verdict got pft=%b exp 011", {pass_a, fail_a, timeout_a});
    end
    vec_cnt++;
    tick();
    if (finish_a !== 1'b0 || cyc_a !== 32'd13 || {pass_a, fail_a, timeout_a} !== 3'b011) begin
      miss_cnt++; $display("FAIL timeout_hold got fin=%b cyc=%0d pft=%b exp fin=0 cyc=13 pft=011",
                           finish_a, cyc_a, {pass_a, fail_a, timeout_a});
    end
    vec_cnt++;
  endtask

  // done at cyc==5 (sampled at E6); optional err the cycle after DRAIN entry.
  task automatic run_pass_case(input bit late_err, input string tag);
    pulse_start_a();
    for (int k = 1; k <= 8; k++) begin
      done_a = (k == 6);
      err_a  = late_err && (k == 7);
      tick();
      done_a = 1'b0;
      err_a  = 1'b0;
      if (cyc_a !== 32'(k)) begin miss_cnt++; $display("FAIL %s_cyc E%0d got %0d exp %0d", tag, k, cyc_a, k); end
      vec_cnt++;
      if (busy_a !== (k < 8) || finish_a !== (k == 8)) begin
        miss_cnt++; $display("FAIL %s_ctl E%0d got busy=%b fin=%b exp busy=%b fin=%b", tag, k, busy_a, finish_a, k < 8, k == 8);
      end
      vec_cnt++;
    end
    if ({pass_a, fail_a, timeout_a} !== (late_err ? 3'b010 : 3'b100)) begin
      miss_cnt++; $display("FAIL %s_verdict got pft=%b exp %b", tag, {pass_a, fail_a, timeout_a}, late_err ? 3'b010 : 3'b100);
    end
    vec_cnt++;
    tick();
    if (finish_a !== 1'b0) begin miss_cnt++; $display("FAIL %s_single_pulse got fin=%b exp 0", tag, finish_a); end
    vec_cnt++;
  endtask

  task automatic test_pass();
    run_pass_case(1'b0, "pass");
  endtask

  task automatic test_err_in_drain();
    run_pass_case(1'b1, "drain_err");
  endtask

  // err+done together at cyc==3; start pokes in RUN and DRAIN are ignored.
  task automatic test_simultaneous();
    pulse_start_a();
    for (int k = 1; k <= 6; k++) begin
      start_a = (k == 2) || (k == 5);
      done_a  = (k == 4);
      err_a   = (k == 4);
      tick();
      start_a = 1'b0;
      done_a  = 1'b0;
      err_a   = 1'b0;
      if (cyc_a !== 32'(k)) begin miss_cnt++; $display("FAIL simul_cyc E%0d got %0d exp %0d", k, cyc_a, k); end
      vec_cnt++;
      if (finish_a !== (k == 6)) begin miss_cnt++; $display("FAIL simul_finish E%0d got %b exp %b", k, finish_a, k == 6); end
      vec_cnt++;
    end
    if ({pass_a, fail_a, timeout_a} !== 3'b010) begin
      miss_cnt++; $display("FAIL simul_verdict got pft=%b exp 010", {pass_a, fail_a, timeout_a});
    end
    vec_cnt++;
  endtask

  // Reset while cyc==4, then a clean run to timeout.
  task automatic test_reset_mid_run();
    int fin_seen;
    pulse_start_a();
    for (int k = 1; k <= 4; k++) tick();
    if (cyc_a !== 32'd4 || busy_a !== 1'b1) begin
      miss_cnt++; $display("FAIL midrst_pre got cyc=%0d busy=%b exp cyc=4 busy=1", cyc_a, busy_a);
    end
    vec_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (cyc_a !== 32'd0 || {busy_a, finish_a, pass_a, fail_a, timeout_a} !== 5'b0) begin
      miss_cnt++; $display("FAIL midrst_post got cyc=%0d flags=%b exp cyc=0 flags=00000",
                           cyc_a, {busy_a, finish_a, pass_a, fail_a, timeout_a});
    end
    vec_cnt++;
    tick();
    if (cyc_a !== 32'd0 || busy_a !== 1'b0 || finish_a !== 1'b0) begin
      miss_cnt++; $display("FAIL midrst_idle got cyc=%0d busy=%b fin=%b exp 0/0/0", cyc_a, busy_a, finish_a);
    end
    vec_cnt++;
    pulse_start_a();
    fin_seen = 0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (finish_a === 1'b1) fin_seen++;
    end
    if (cyc_a !== 32'd13 || fin_seen != 1 || {pass_a, fail_a, timeout_a} !== 3'b011) begin
      miss_cnt++; $display("FAIL midrst_rerun got cyc=%0d pulses=%0d pft=%b exp cyc=13 pulses=1 pft=011",
                           cyc_a, fin_seen, {pass_a, fail_a, timeout_a});
    end
    vec_cnt++;
  endtask

  // Instance b: zero drain, pass at cyc==2, then restart from DONE to timeout.
  task automatic test_drain0_restart();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      done_b = (k == 3);
      tick();
      done_b = 1'b0;
      if (cyc_b !== 32'(k) || busy_b !== (k < 3) || finish_b !== (k == 3)) begin
        miss_cnt++; $display("FAIL d0_run E%0d got cyc=%0d busy=%b fin=%b exp cyc=%0d busy=%b fin=%b",
                             k, cyc_b, busy_b, finish_b, k, k < 3, k == 3);
      end
      vec_cnt++;
    end
    if ({pass_b, fail_b, timeout_b} !== 3'b100) begin
      miss_cnt++; $display("FAIL d0_verdict got pft=%b exp 100", {pass_b, fail_b, timeout_b});
    end
    vec_cnt++;
    tick();
    if (finish_b !== 1'b0 || pass_b !== 1'b1) begin
      miss_cnt++; $display("FAIL d0_hold got fin=%b pass=%b exp fin=0 pass=1", finish_b, pass_b);
    end
    vec_cnt++;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    if (cyc_b !== 32'd0 || {busy_b, finish_b, pass_b, fail_b, timeout_b} !== 5'b10000) begin
      miss_cnt++; $display("FAIL d0_restart got cyc=%0d flags=%b exp cyc=0 flags=10000",
                           cyc_b, {busy_b, finish_b, pass_b, fail_b, timeout_b});
    end
    vec_cnt++;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (finish_b !== (k == 11)) begin miss_cnt++; $display("FAIL d0_second_finish E%0d got %b exp %b", k, finish_b, k == 11); end
      vec_cnt++;
    end
    if (cyc_b !== 32'd11 || {pass_b, fail_b, timeout_b} !== 3'b011) begin
      miss_cnt++; $display("FAIL d0_timeout got cyc=%0d pft=%b exp cyc=11 pft=011", cyc_b, {pass_b, fail_b, timeout_b});
    end
    vec_cnt++;
  endtask

  // Test sequence and final report.
  initial begin
    vec_cnt  = 0;
    miss_cnt = 0;
    rst      = 1'b1;
    start_a  = 1'b0; done_a = 1'b0; err_a = 1'b0;
    start_b  = 1'b0; done_b = 1'b0; err_b = 1'b0;
    tick();
    test_reset();
    test_timeout();
    test_pass();
    test_err_in_drain();
    test_simultaneous();
    test_reset_mid_run();
    test_drain0_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
